circuit1_pipe: RTL and testbench
================================

# circuit1_pipe

Parametrised, pipelined successor of the Circuit1 datapath. It computes `d = a+b`, `e = a+c`, `g = d>e`, `z = g ? d : e`, `f = a*c` and `x = f-d` over a configurable operand width. It adds valid/ready handshaking on input and output, giving full throughput and lossless backpressure. It sits between an upstream operand producer and a downstream result consumer in the HLSM-generated circuit set.

## Interface
- `DATAW`, 8, operand width in bits; `a`/`b`/`c`/`d`/`e`/`z` are DATAW wide, `f`/`x` are 2*DATAW wide; legal range 2..32.
- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand triple valid.
- `in_ready`  out  1  block accepts the triple this cycle.
- `a`, `b`, `c`  in  DATAW each  unsigned operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `z`  out  DATAW  max of d and e.
- `x`  out  2*DATAW  f minus zero-extended d.
- `g`  out  1  compare flag, d > e.
- `sat`  out  1  x was clamped; constant 0 unless `CIRCUIT1_SAT_EN` is defined.

## Operation
- Transfer on the input side: `in_valid && in_ready`. Transfer on the output side: `out_valid && out_ready`.
- Stage 1, registered on input transfer: `d` and `e` are computed mod 2^DATAW (carry dropped); `f = a*c` is kept at full 2*DATAW; the stage-1 valid bit is `s1_v`.
- Stage 2, the output register:
  - `g = (d > e)`, unsigned compare.
  - `z = g ? d : e`.
  - `x = f - {DATAW'b0, d}`, taken mod 2^(2*DATAW).
  - Sets `out_valid`.
- Advance rules:
  - `adv2 = !out_valid || out_ready`.
  - `adv1 = !s1_v || adv2`.
  - `in_ready = adv1`.
- When a stage does not advance, it holds its data and valid bit unchanged. No transfer is dropped or duplicated.
- When stage 2 advances and `s1_v = 0`, `out_valid` clears.
- Operand values while `in_valid = 0` are don't-care and are never captured.
- Reset, while asserted or asserted mid-operation:
  - `s1_v`, `out_valid`, `z`, `x`, `g` and `sat` go to 0 asynchronously.
  - All in-flight data is discarded.
  - `in_ready` reads 1 as soon as `Rst` is high and no data is held.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline shifts by one with no bubble.

## Timing
- Latency: 2 cycles, from the input transfer edge to `out_valid` high with the matching result.
- Throughput: 1 result per cycle while `out_ready = 1`.
- Capacity: 2 results in flight. With `out_ready = 0`, a third triple is refused (`in_ready = 0`).
- `in_ready` is combinational from `out_ready`; this is the only combinational input-to-output path.
- All data outputs are driven directly from registers.

## Configuration
- `CIRCUIT1_SAT_EN` defined:
  - When `f < d`, `x` is clamped to 0 and `sat = 1` for that result.
  - Otherwise `sat = 0`.
- `CIRCUIT1_SAT_EN` undefined:
  - `x` wraps mod 2^(2*DATAW).
  - `sat` is tied to 0 and is still present as a port.
- The macro changes no other behaviour or latency.

## Structure
- Package `circuit_pkg`:
  - `DATAW_DEF = 8`.
  - Width helper constants `PRODW = 2*DATAW`.
  - Typedefs for the stage-1 payload struct (`d`, `e`, `f`) and the stage-2 payload struct (`z`, `x`, `g`, `sat`).
- Sub-module `pipe_stage`:
  - Parametrised payload width; valid-qualified register with hold-on-stall and async active-low clear.
  - Instantiated twice.
  - The arithmetic stays in the top module.

## Test plan
- Basic, DATAW=8: `a=10, b=5, c=3` -> after 2 cycles `z=15, g=1, x=15, sat=0`.
- Wrap, DATAW=8: `a=200, b=100, c=1` -> `d=44, e=201`, so `g=0, z=201, x=156`.
- Negative difference, DATAW=8: `a=1, b=9, c=2` -> `x=0xFFF8, sat=0` without the macro; `x=0, sat=1` with `CIRCUIT1_SAT_EN`.
- Backpressure:
  - Hold `out_ready=0` and offer triples T1, T2, T3 back-to-back.
  - T1 and T2 are accepted and T3 waits (`in_ready=0`); outputs hold T1.
  - Raise `out_ready` -> T1, T2, T3 emerge in order with no loss or duplication.
- Streaming: 16 random triples with `in_valid` and `out_ready` both held high -> 16 results on consecutive cycles matching the reference model.
- Reset mid-operation: drive `Rst` low while 2 results are in flight -> `out_valid`, `z`, `x`, `g`, `sat` read 0 immediately; after release, the first new triple produces a correct result 2 cycles later.

Source files
------------

// File: rtl/circuit_pkg.sv
// Shared widths and payload layouts for the Circuit1 pipelined datapath.
// Optional x clamping is enabled by defining CIRCUIT1_SAT_EN.
package circuit_pkg;
   localparam int DATAW_DEF = 8;
   localparam int PRODW_DEF = 2 * DATAW_DEF;

   // Payload layouts at the default operand width.
   typedef struct packed {
      logic [DATAW_DEF-1:0] d;
      logic [DATAW_DEF-1:0] e;
      logic [PRODW_DEF-1:0] f;
   } s1_pay_t;

   typedef struct packed {
      logic [DATAW_DEF-1:0] z;
      logic [PRODW_DEF-1:0] x;
      logic                 g;
      logic                 sat;
   } s2_pay_t;

   function automatic int prodw(input int dataw);
      return 2 * dataw;
   endfunction
endpackage

// File: rtl/circuit1_pipe_stage.sv
// Valid-qualified pipeline register: loads when enabled, holds on stall,
// clears asynchronously on active-low reset.
module pipe_stage
   import circuit_pkg::*;
#(
   parameter int W = DATAW_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_vld,
   input  logic [W-1:0] din,
   output logic         vld,
   output logic [W-1:0] dout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         dout <= '0;
      end else if (en) begin
         vld <= in_vld;
         if (in_vld) dout <= din;
      end
   end

endmodule

// File: rtl/circuit1_pipe.sv
// Two-stage Circuit1 datapath with valid/ready on both sides.
// Define CIRCUIT1_SAT_EN to clamp x at zero when f < d and report it on sat.
module circuit1_pipe
   import circuit_pkg::*;
#(
   parameter int DATAW = DATAW_DEF
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATAW-1:0]   a,
   input  logic [DATAW-1:0]   b,
   input  logic [DATAW-1:0]   c,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATAW-1:0]   z,
   output logic [2*DATAW-1:0] x,
   output logic               g,
   output logic               sat
);

   localparam int PRODW = prodw(DATAW);

   typedef struct packed {
      logic [DATAW-1:0] d;
      logic [DATAW-1:0] e;
      logic [PRODW-1:0] f;
   } s1_t;

   typedef struct packed {
      logic [DATAW-1:0] z;
      logic [PRODW-1:0] x;
      logic             g;
      logic             sat;
   } s2_t;

   function automatic s2_t finish_result(input s1_t p);
      s2_t              r;
      logic [PRODW-1:0] d_ext;
      d_ext = {{DATAW{1'b0}}, p.d};
      r.g   = (p.d > p.e);
      r.z   = r.g ? p.d : p.e;
`ifdef CIRCUIT1_SAT_EN
      if (p.f < d_ext) begin
         r.x   = '0;
         r.sat = 1'b1;
      end else begin
         r.x   = p.f - d_ext;
         r.sat = 1'b0;
      end
`else
      r.x   = p.f - d_ext;
      r.sat = 1'b0;
`endif
      return r;
   endfunction

   logic s1_v;
   logic adv1;
   logic adv2;
   s1_t  s1_in;
   s1_t  s1_q;
   s2_t  s2_in;
   s2_t  s2_q;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_v || adv2;
   assign in_ready = adv1;

   always_comb begin
      s1_in.d = a + b;
      s1_in.e = a + c;
      s1_in.f = {{DATAW{1'b0}}, a} * {{DATAW{1'b0}}, c};
   end

   // Stage 1: sums and full-width product
   pipe_stage #(.W($bits(s1_t))) u_stage1 (
      .clk    (Clk),
      .rst_n  (Rst),
      .en     (adv1),
      .in_vld (in_valid),
      .din    (s1_in),
      .vld    (s1_v),
      .dout   (s1_q)
   );

   assign s2_in = finish_result(s1_q);

   // Stage 2: compare/select/subtract, output register
   pipe_stage #(.W($bits(s2_t))) u_stage2 (
      .clk    (Clk),
      .rst_n  (Rst),
      .en     (adv2),
      .in_vld (s1_v),
      .din    (s2_in),
      .vld    (out_valid),
      .dout   (s2_q)
   );

   assign z   = s2_q.z;
   assign x   = s2_q.x;
   assign g   = s2_q.g;
   assign sat = s2_q.sat;

endmodule

// File: tb/tb_circuit1_pipe.sv
// Scoreboard bench for circuit1_pipe: randomized triples against an arithmetic model.
module tb_circuit1_pipe;
   localparam int DW = 8;
   localparam int PW = 2 * DW;

   typedef struct packed {
      logic [DW-1:0] z;
      logic [PW-1:0] x;
      logic          g;
      logic          sat;
   } res_t;

   logic          Clk;
   logic          Rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a, b, c;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] z;
   logic [PW-1:0] x;
   logic          g;
   logic          sat;

   res_t sb[$];
   int   checks;
   int   errors;
   int   n_out;

   circuit1_pipe #(.DATAW(DW)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .x         (x),
      .g         (g),
      .sat       (sat)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain-arithmetic model of one result.
   function automatic res_t model(input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                                  input logic [DW-1:0] ic);
      longint unsigned m1, m2, d, e, f;
      res_t r;
      m1    = 64'd1 << DW;
      m2    = 64'd1 << PW;
      d     = (64'(ia) + 64'(ib)) % m1;
      e     = (64'(ia) + 64'(ic)) % m1;
      f     = 64'(ia) * 64'(ic);
      r.g   = (d > e);
      r.z   = DW'(r.g ? d : e);
      r.x   = PW'((f + m2 - d) % m2);
      r.sat = 1'b0;
`ifdef CIRCUIT1_SAT_EN
      if (f < d) begin
         r.x   = '0;
         r.sat = 1'b1;
      end
`endif
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return DW'($urandom);
      endcase
   endfunction

   // Monitor pops on output transfer; stimulus side pushes on input transfer.
   always @(negedge Clk) begin
      if (!Rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               res_t e;
               e = sb.pop_front();
               check("result", 64'({z, x, g, sat}), 64'(e));
            end
         end
         if (in_valid && in_ready) sb.push_back(model(a, b, c));
      end
   end

   task automatic send(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic [DW-1:0] ic);
      int n;
      n = 0;
      a = ia; b = ib; c = ic; in_valid = 1'b1;
      @(negedge Clk);
      while (!in_ready && n < 50) begin
         @(posedge Clk); #1;
         @(negedge Clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 64'd1, 64'd0);
      @(posedge Clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic directed(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic [DW-1:0] ic,
                           input logic [DW-1:0] ez, input logic [PW-1:0] ex,
                           input logic eg, input logic esat);
      @(posedge Clk); #1;
      a = ia; b = ib; c = ic; in_valid = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      @(negedge Clk);
      check("latency_early", 64'(out_valid), 64'd0);
      @(negedge Clk);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("dir_z", 64'(z), 64'(ez));
      check("dir_x", 64'(x), 64'(ex));
      check("dir_g", 64'(g), 64'(eg));
      check("dir_sat", 64'(sat), 64'(esat));
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check("drain_done", 64'(n < 100), 64'd1);
   endtask

   initial begin
      logic [DW-1:0] ta [3];
      logic [DW-1:0] tb_ [3];
      logic [DW-1:0] tc [3];
      res_t r1, rp;
      int   base;
      logic [DW-1:0] ra, rb, rc;

      checks = 0; errors = 0; n_out = 0;
      Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c = '0;

      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_z", 64'(z), 64'd0);
      check("rst_x", 64'(x), 64'd0);
      check("rst_g", 64'(g), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b1;
      #1 check("rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      directed(8'd10, 8'd5, 8'd3, 8'd15, 16'd15, 1'b1, 1'b0);
      directed(8'd200, 8'd100, 8'd1, 8'd201, 16'd156, 1'b0, 1'b0);
`ifdef CIRCUIT1_SAT_EN
      directed(8'd1, 8'd9, 8'd2, 8'd10, 16'd0, 1'b1, 1'b1);
`else
      directed(8'd1, 8'd9, 8'd2, 8'd10, 16'hFFF8, 1'b1, 1'b0);
`endif
      drain();

      // Backpressure: two accepted, third refused while output stalls.
      @(posedge Clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ta[i] = DW'($urandom); tb_[i] = DW'($urandom); tc[i] = DW'($urandom);
      end
      r1   = model(ta[0], tb_[0], tc[0]);
      base = n_out;
      send(ta[0], tb_[0], tc[0]);
      send(ta[1], tb_[1], tc[1]);
      a = ta[2]; b = tb_[2]; c = tc[2]; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_hold", 64'({z, x, g, sat}), 64'(r1));
         @(posedge Clk); #1;
      end
      out_ready = 1'b1;
      @(negedge Clk);
      check("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      drain();
      check("bp_count", 64'(n_out - base), 64'd3);

      // Streaming: one result per cycle.
      @(posedge Clk); #1;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
               in_valid = 1'b1;
               @(posedge Clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            int run, w;
            run = 0; w = 0;
            @(negedge Clk);
            while (!out_valid && w < 10) begin
               @(negedge Clk);
               w++;
            end
            while (out_valid && run < 40) begin
               run++;
               @(negedge Clk);
            end
            check("stream_run", 64'(run), 64'd16);
         end
      join
      drain();

      // Random valid/ready mix with corner operands.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a = rand_op(); b = rand_op(); c = rand_op();
         @(posedge Clk); #1;
      end
      in_valid = 1'b0;
      drain();

      // Reset with two results in flight.
      @(posedge Clk); #1;
      out_ready = 1'b0;
      send(DW'($urandom), DW'($urandom), DW'($urandom));
      send(DW'($urandom), DW'($urandom), DW'($urandom));
      check("pre_rst_ready", 64'(in_ready), 64'd0);
      Rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_z", 64'(z), 64'd0);
      check("midrst_x", 64'(x), 64'd0);
      check("midrst_g", 64'(g), 64'd0);
      check("midrst_sat", 64'(sat), 64'd0);
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b1;
      #1 check("post_rst_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      ra = DW'($urandom); rb = DW'($urandom); rc = DW'($urandom);
      rp = model(ra, rb, rc);
      directed(ra, rb, rc, rp.z, rp.x, rp.g, rp.sat);
      drain();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
